// File: rtl/adxl345_axis_assembler_pkg.sv
// Shared types and constants for the ADXL345 axis assembler.
// Holds the FSM encoding and the DATAX0..DATAZ1 register window.
package adxl345_axis_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] ADXL_DATA_BASE   = 8'h32;
  localparam logic [7:0] ADXL_DATA_LAST   = 8'h37;
  // One sample spans the whole DATAX0..DATAZ1 register window.
  localparam int         BYTES_PER_SAMPLE = int'(ADXL_DATA_LAST - ADXL_DATA_BASE) + 1;

endpackage

// File: rtl/adxl345_axis_assembler_i2c_byte_deserializer.sv
// MSB-first I2C byte shifter clocked by SCL rising edges detected in the system clock domain.
// Byte_o/valid appear the cycle after the 8th rise; no backpressure, caller gates shifting via i_shift_en.
module i2c_byte_deserializer #(
  parameter int BYTE_WIDTH_P = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_scl,
  input  logic                    i_sda,
  input  logic                    i_start,
  input  logic                    i_shift_en,
  output logic                    o_byte_done,
  output logic [BYTE_WIDTH_P-1:0] o_byte,
  output logic                    o_byte_vld
);

  localparam int                CNT_W    = $clog2(BYTE_WIDTH_P);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_WIDTH_P - 1);

  logic                    r_scl_d;
  logic [BYTE_WIDTH_P-2:0] r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;

  logic                    w_scl_rise;
  logic                    w_step;
  logic [BYTE_WIDTH_P-1:0] w_next;

  assign w_scl_rise  = i_scl & ~r_scl_d;
  assign w_step      = i_shift_en & w_scl_rise;
  assign w_next      = {r_shift, i_sda};
  assign o_byte_done = w_step && (r_bit_cnt == LAST_BIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scl_d    <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      o_byte     <= '0;
      o_byte_vld <= 1'b0;
    end else begin
      r_scl_d    <= i_scl;
      o_byte_vld <= 1'b0;
      if (i_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_step) begin
        r_shift   <= w_next[BYTE_WIDTH_P-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          o_byte     <= w_next;
          o_byte_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adxl345_axis_assembler.sv
// Collects six I2C read frames into X/Y/Z words; Sample_Valid_o 2 cycles after the 6th Data_Available_i.
// No backpressure: every output is a one-cycle pulse or a held register.
module adxl345_axis_assembler
  import adxl345_axis_assembler_pkg::*;
#(
  parameter int BYTES_PER_SAMPLE_P = BYTES_PER_SAMPLE,
  parameter int BYTE_WIDTH_P       = 8,
  parameter int AXIS_WIDTH_P       = 16
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Scl_i,
  input  logic                    Sda_i,
  input  logic                    Capture_En_i,
  input  logic                    Data_Available_i,
  input  logic                    Resync_i,
  output logic [BYTE_WIDTH_P-1:0] Byte_o,
  output logic                    Byte_Valid_o,
  output logic [AXIS_WIDTH_P-1:0] Axis_X_o,
  output logic [AXIS_WIDTH_P-1:0] Axis_Y_o,
  output logic [AXIS_WIDTH_P-1:0] Axis_Z_o,
  output logic                    Sample_Valid_o,
  output logic                    Frame_Error_o
);

  localparam int IDX_W = $clog2(BYTES_PER_SAMPLE_P);
  localparam int NSLOT = BYTES_PER_SAMPLE_P - 1;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_byte_idx;
  logic [BYTE_WIDTH_P-1:0] r_slot [NSLOT];

  logic w_start;
  logic w_shift_en;
  logic w_byte_done;
  logic w_last;

  // Resync and a stray Data_Available both force IDLE, so neither may start or advance a byte.
  assign w_start    = (r_state == ST_IDLE)  && Capture_En_i && !Data_Available_i && !Resync_i;
  assign w_shift_en = (r_state == ST_SHIFT) && Capture_En_i && !Data_Available_i && !Resync_i;
  assign w_last     = (r_byte_idx == IDX_W'(BYTES_PER_SAMPLE_P - 1));

  i2c_byte_deserializer #(
    .BYTE_WIDTH_P(BYTE_WIDTH_P)
  ) u_deser (
    .i_clk       (Clk_i),
    .i_reset     (Reset_i),
    .i_scl       (Scl_i),
    .i_sda       (Sda_i),
    .i_start     (w_start),
    .i_shift_en  (w_shift_en),
    .o_byte_done (w_byte_done),
    .o_byte      (Byte_o),
    .o_byte_vld  (Byte_Valid_o)
  );

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_state        <= ST_IDLE;
      r_byte_idx     <= '0;
      for (int i = 0; i < NSLOT; i++) r_slot[i] <= '0;
      Axis_X_o       <= '0;
      Axis_Y_o       <= '0;
      Axis_Z_o       <= '0;
      Sample_Valid_o <= 1'b0;
      Frame_Error_o  <= 1'b0;
    end else begin
      Sample_Valid_o <= 1'b0;
      Frame_Error_o  <= 1'b0;
      if (Resync_i) begin
        r_state    <= ST_IDLE;
        r_byte_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Data_Available_i) begin
              Frame_Error_o <= 1'b1;
              r_byte_idx    <= '0;
            end else if (Capture_En_i) begin
              r_state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (Data_Available_i) begin
              Frame_Error_o <= 1'b1;
              r_byte_idx    <= '0;
              r_state       <= ST_IDLE;
            end else if (!Capture_En_i) begin
              r_state <= ST_IDLE;
            end else if (w_byte_done) begin
              r_state <= ST_HOLD;
            end
          end
          // SCL keeps toggling here for the NACK clock; only the frame end matters.
          ST_HOLD: begin
            if (Data_Available_i) r_state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            r_state <= ST_IDLE;
            if (w_last) begin
              Axis_X_o       <= {r_slot[1], r_slot[0]};
              Axis_Y_o       <= {r_slot[3], r_slot[2]};
              Axis_Z_o       <= {Byte_o, r_slot[4]};
              Sample_Valid_o <= 1'b1;
              r_byte_idx     <= '0;
            end else begin
              for (int i = 0; i < NSLOT; i++) begin
                if (r_byte_idx == IDX_W'(i)) r_slot[i] <= Byte_o;
              end
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
